// File: rtl/mmio_port_responder.sv
// ============================================================================
// Module      : mmio_port_responder
// Description : Memory-mapped I/O port on the processor data bus: OUT/IN/EDGE/MASK
//               registers, 2-FF input synchronizer, W1C rising-edge status and a
//               one-cycle Ready handshake. Optional IRQ output when PORT_IRQ_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [31:0]         ReadData,
    output logic                Ready,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut
`ifdef PORT_IRQ_EN
    ,
    output logic                IRQ
`endif
);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_resp = 1'b1;

    localparam logic [1:0] c_sel_out  = 2'b00;
    localparam logic [1:0] c_sel_in   = 2'b01;
    localparam logic [1:0] c_sel_edge = 2'b10;
    localparam logic [1:0] c_sel_mask = 2'b11;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_prev;
    logic [IN_WIDTH-1:0] r_edge;
    logic [IN_WIDTH-1:0] r_mask;
    logic [31:0]         r_out;
    logic [31:0]         r_rdata;

    logic [1:0]          w_sel;
    logic                w_req;
    logic                w_acc;
    logic                w_wr;
    logic                w_rd;
    logic [IN_WIDTH-1:0] w_rise;
    logic [IN_WIDTH-1:0] w_clr;
    logic [31:0]         w_rmux;
    logic [1:0]          w_unused_addr;

    // Word accesses only: the byte offset carries no meaning here.
    assign w_unused_addr = Address[1:0];

    assign Hit    = (Address[31:4] == BASE_ADDR[31:4]);
    assign w_sel  = Address[3:2];
    assign w_req  = (MemRead | MemWrite) & Hit;
    assign w_acc  = (r_state == c_idle) & w_req;
    assign w_wr   = w_acc & MemWrite;
    assign w_rd   = w_acc & MemRead & ~MemWrite;
    assign w_rise = r_sync2 & ~r_prev;
    assign w_clr  = (w_wr && (w_sel == c_sel_edge)) ? WriteData[IN_WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_req) w_next_state = c_resp;
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        Ready = 1'b0;
        if (r_state == c_resp) Ready = 1'b1;
    end

    always_comb begin
        w_rmux = 32'h0;
        case (w_sel)
            c_sel_out:  w_rmux = r_out;
            c_sel_in:   w_rmux = 32'(r_sync2);
            c_sel_edge: w_rmux = 32'(r_edge);
            c_sel_mask: w_rmux = 32'(r_mask);
            default:    w_rmux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
            r_mask  <= '0;
            r_out   <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Set has priority over a simultaneous W1C on the same bit.
            r_edge  <= (r_edge & ~w_clr) | (w_rise & r_mask);
            if (w_wr && (w_sel == c_sel_out))  r_out  <= WriteData;
            if (w_wr && (w_sel == c_sel_mask)) r_mask <= WriteData[IN_WIDTH-1:0];
            r_rdata <= w_rd ? w_rmux : 32'h0;
        end
    end

    assign ReadData = r_rdata;
    assign PortOut  = r_out;

`ifdef PORT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_edge;
        end
    end

    assign IRQ = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmio_port_responder.sv
// ============================================================================
// Module      : tb_mmio_port_responder
// Description : Self-checking bench for mmio_port_responder (vector table plus
//               scoreboard queue for read data, hand sequences for corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_port_responder;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
`ifdef PORT_IRQ_EN
    logic        IRQ;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut)
`ifdef PORT_IRQ_EN
        ,
        .IRQ       (IRQ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus access; the expected read data rides the scoreboard until Ready.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        Address   = addr;
        WriteData = wdata;
        MemWrite  = we;
        MemRead   = re;
        exp_q.push_back(exp_rd);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        check("ready_pulse", 32'(Ready), 32'd1);
        check("read_data", ReadData, exp_q.pop_front());
        @(posedge clk); #1;
        check("ready_idle", 32'(Ready), 32'd0);
        check("read_data_idle", ReadData, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_000C, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_000C, 32'h0000_0000, 32'h0000_00FF, 32'h1234_5678};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_000C, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_0004, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_0003, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};

        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Reset state and address decode
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_portout", PortOut, 32'h0);
        check("hit_miss", 32'(Hit), 32'd0);
        Address = 32'hFFFF_000C; #1;
        check("hit_top_word", 32'(Hit), 32'd1);
        Address = 32'hFFFF_0010; #1;
        check("hit_past_window", 32'(Hit), 32'd0);

        for (int i = 0; i < 13; i++) begin
            access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
            check($sformatf("portout_v%0d", i), PortOut, vecs[i].exp_out);
        end

        // Access outside the window is ignored
        Address   = 32'h1001_0000;
        WriteData = 32'h0BAD_0BAD;
        MemWrite  = 1'b1; #1;
        check("hit_dmem", 32'(Hit), 32'd0);
        @(posedge clk); #1;
        check("miss_ready", 32'(Ready), 32'd0);
        MemWrite = 1'b0;
        @(posedge clk); #1;
        check("miss_ready2", 32'(Ready), 32'd0);
        check("miss_portout", PortOut, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 32'hDEAD_BEEF);

        // Synchronized input and edge capture (MASK=01)
        PortIn = 8'hA5;
        repeat (3) @(posedge clk); #1;
        access(1'b0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_00A5);
        access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0001);
        access(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0001, 32'h0);
        access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0000);
        PortIn = 8'h00;
        repeat (3) @(posedge clk); #1;
        access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0000);

        // Rise lands in the same cycle as a W1C of that bit: set wins
        PortIn = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0001, 32'h0);
        access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0001);
        access(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0001, 32'h0);
        access(1'b0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0000);

        // Held write: Ready 0,1,0,1
        Address   = 32'hFFFF_0000;
        WriteData = 32'hCAFE_F00D;
        MemWrite  = 1'b1;
        check("hold_c0", 32'(Ready), 32'd0);
        @(posedge clk); #1;
        check("hold_c1", 32'(Ready), 32'd1);
        check("hold_portout", PortOut, 32'hCAFE_F00D);
        @(posedge clk); #1;
        check("hold_c2", 32'(Ready), 32'd0);
        @(posedge clk); #1;
        check("hold_c3", 32'(Ready), 32'd1);
        MemWrite = 1'b0;
        @(posedge clk); #1;
        check("hold_c4", 32'(Ready), 32'd0);
        check("hold_portout2", PortOut, 32'hCAFE_F00D);

        // Reset asserted during RESP
        WriteData = 32'h1111_2222;
        MemWrite  = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ready", 32'(Ready), 32'd1);
        check("pre_rst_portout", PortOut, 32'h1111_2222);
        reset    = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("async_rst_ready", 32'(Ready), 32'd0);
        check("async_rst_portout", PortOut, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'hFFFF_000C, 32'h0, 32'h0000_0000);
        access(1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 32'h0000_0000);

`ifdef PORT_IRQ_EN
        access(1'b1, 1'b0, 32'hFFFF_000C, 32'h0000_0001, 32'h0);
        PortIn = 8'h00;
        repeat (3) @(posedge clk); #1;
        check("irq_idle", 32'(IRQ), 32'd0);
        PortIn = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq_edge_cycle", 32'(IRQ), 32'd0);
        @(posedge clk); #1;
        check("irq_set", 32'(IRQ), 32'd1);
        Address   = 32'hFFFF_0008;
        WriteData = 32'h0000_0001;
        MemWrite  = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        check("irq_clr_cycle", 32'(IRQ), 32'd1);
        @(posedge clk); #1;
        check("irq_cleared", 32'(IRQ), 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
